// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Sits on the free-running reference clock, watches the system PLL's lock
// indicator and owns the PLL's rst input. Once lock has been stable for
// LOCK_STABLE_CYCLES cycles, the staged design resets are released one at a
// time, bit 0 first, STAGE_DELAY cycles apart. A lock drop while releasing
// or running puts every stage back into reset and waits for lock again
// without touching the PLL. A PLL that never locks within LOCK_TIMEOUT
// cycles gets a fresh PLL_RST_CYCLES-wide reset pulse.
//
// Ports
//   clk            in   reference clock, free-running
//   rst            in   synchronous, active-high reset
//   pll_locked     in   PLL locked output, asynchronous to clk
//   pll_rst        out  reset to the PLL rst input
//   rst_out        out  [NUM_STAGES] active-high staged resets, bit 0 first
//   ready          out  all stages released with lock qualified
//   lock_loss_cnt  out  [8] lock-loss events, saturating at 255
//   timeout_err    out  sticky lock-timeout flag, cleared only by rst
//
// Every output comes straight from a flop. Downstream logic in the PLL
// output clock domains re-synchronizes rst_out locally.
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int NUM_STAGES         = 3,
    parameter int LOCK_TIMEOUT       = 1000000,
    parameter int PLL_RST_CYCLES     = 8,
    parameter int CNT_W              = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [7:0]            lock_loss_cnt,
    output logic                  timeout_err
);

    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    // Counters compare against "last value" so that the transition fires on
    // the cycle the count would reach its target.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DLY_LAST     = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [CNT_W-1:0]       rst_cnt;
    logic [CNT_W-1:0]       wait_cnt;
    logic [CNT_W-1:0]       stable_cnt;
    logic [CNT_W-1:0]       dly;
    logic [IDX_W-1:0]       idx;

    // Plain shift-register synchronizer for the asynchronous lock input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_PLL_RST;
            pll_rst       <= 1'b1;
            rst_out       <= '1;
            ready         <= 1'b0;
            lock_loss_cnt <= 8'd0;
            timeout_err   <= 1'b0;
            rst_cnt       <= '0;
            wait_cnt      <= '0;
            stable_cnt    <= '0;
            dly           <= '0;
            idx           <= '0;
        end else if ((state == S_RELEASE || state == S_RUN) && !locked_s) begin
            // Lock loss beats any stage release due this cycle. The PLL is
            // left alone; we only wait for it to re-lock.
            state      <= S_WAIT_LOCK;
            rst_out    <= '1;
            ready      <= 1'b0;
            wait_cnt   <= '0;
            stable_cnt <= '0;
            if (lock_loss_cnt != 8'hFF) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (rst_cnt == PLL_RST_LAST) begin
                        state      <= S_WAIT_LOCK;
                        pll_rst    <= 1'b0;
                        rst_cnt    <= '0;
                        wait_cnt   <= '0;
                        stable_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    wait_cnt   <= wait_cnt + 1'b1;
                    stable_cnt <= locked_s ? stable_cnt + 1'b1 : '0;
                    // Stable lock is tested first so it wins a tie with the
                    // timeout.
                    if (locked_s && stable_cnt == STABLE_LAST) begin
                        state <= S_RELEASE;
                        idx   <= '0;
                        dly   <= '0;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        state       <= S_PLL_RST;
                        pll_rst     <= 1'b1;
                        rst_cnt     <= '0;
                        timeout_err <= 1'b1;
                    end
                end

                S_RELEASE: begin
                    if (dly == DLY_LAST) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (IDX_W'(i) == idx) begin
                                rst_out[i] <= 1'b0;
                            end
                        end
                        idx <= idx + 1'b1;
                        dly <= '0;
                        if (idx == IDX_LAST) begin
                            state <= S_RUN;
                            ready <= 1'b1;
                        end
                    end else begin
                        dly <= dly + 1'b1;
                    end
                end

                S_RUN: begin
                    state <= S_RUN;
                end

                default: begin
                    state   <= S_PLL_RST;
                    pll_rst <= 1'b1;
                    rst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with small parameters. Each step
// that drives pll_locked pushes the output changes it must cause onto
// exp_q as {cycle offset from mark, pll_rst, ready, rst_out}; the sampler
// in step() pops one entry for every observed output change and checks
// both the value and the cycle it appeared on. Counters and sticky flags
// are checked directly at fixed points.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int NS  = 3;
    localparam int SBW = 32 + 2 + NS;

    logic          clk;
    logic          rst;
    logic          pll_locked;
    logic          pll_rst;
    logic [NS-1:0] rst_out;
    logic          ready;
    logic [7:0]    lock_loss_cnt;
    logic          timeout_err;

    logic [SBW-1:0] exp_q[$];
    int             checks;
    int             failures;
    int             cyc;
    int             mark;
    logic           mon_en;
    logic [4:0]     prev;

    pll_reset_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(16),
        .STAGE_DELAY       (4),
        .NUM_STAGES        (NS),
        .LOCK_TIMEOUT      (100),
        .PLL_RST_CYCLES    (8),
        .CNT_W             (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .rst_out      (rst_out),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_err  (timeout_err)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard sampler, run on the falling edge inside step().
    task automatic sample();
        logic [4:0]     obs;
        logic [SBW-1:0] e;
        logic [31:0]    at;
        obs = {pll_rst, ready, rst_out};
        at  = 32'(cyc - mark);
        if (mon_en && obs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL sb_unexpected observed=%b at=%0d expected=no change", obs, at);
            end else begin
                e = exp_q.pop_front();
                assert (obs === e[4:0] && at === e[SBW-1:5]) else begin
                    failures++;
                    $error("FAIL sb_change observed=%b@%0d expected=%b@%0d",
                           obs, at, e[4:0], e[SBW-1:5]);
                end
            end
        end
        prev = obs;
    endtask

    // Each step ends 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int at, input logic [4:0] w);
        exp_q.push_back({32'(at), w});
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) step(1);
        chk(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset(input logic lk);
        mon_en     = 1'b0;
        rst        = 1'b1;
        pll_locked = lk;
        step(3);
        rst = 1'b0;
        exp_q.delete();
        mark = cyc;
        chk("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk("rst_rst_out", 32'(rst_out), 32'b111);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        mon_en = 1'b1;
    endtask

    // From RUN: drop lock, relock 5 cycles later, full staged release.
    task automatic loss_relock();
        mark = cyc;
        push(3,  5'b00_111);
        push(27, 5'b00_110);
        push(31, 5'b00_100);
        push(35, 5'b01_000);
        pll_locked = 1'b0;
        step(5);
        pll_locked = 1'b1;
        drain("loss_relock_drain", 60);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        mark       = 0;
        mon_en     = 1'b0;
        prev       = '0;
        rst        = 1'b1;
        pll_locked = 1'b0;

        // 1: startup with lock held
        do_reset(1'b1);
        push(8,  5'b00_111);
        push(28, 5'b00_110);
        push(32, 5'b00_100);
        push(36, 5'b01_000);
        drain("t1_drain", 80);
        chk("t1_loss_cnt", 32'(lock_loss_cnt), 32'd0);

        // 3: lock loss in RUN, then relock
        loss_relock();
        chk("t3_loss_cnt", 32'(lock_loss_cnt), 32'd1);
        chk("t3_timeout", 32'(timeout_err), 32'd0);

        // 2: glitchy lock restarts the stable count
        do_reset(1'b0);
        push(8,  5'b00_111);
        push(41, 5'b00_110);
        push(45, 5'b00_100);
        push(49, 5'b01_000);
        step(8);
        pll_locked = 1'b1;
        step(10);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        drain("t2_drain", 80);

        // 4: lock timeout, repeated PLL reset, then a normal lock
        do_reset(1'b0);
        push(8,   5'b00_111);
        push(108, 5'b10_111);
        push(116, 5'b00_111);
        push(216, 5'b10_111);
        push(224, 5'b00_111);
        push(252, 5'b00_110);
        push(256, 5'b00_100);
        push(260, 5'b01_000);
        step(107);
        chk("t4_timeout_before", 32'(timeout_err), 32'd0);
        step(1);
        chk("t4_timeout_set", 32'(timeout_err), 32'd1);
        step(122);
        pll_locked = 1'b1;
        drain("t4_drain", 80);
        chk("t4_timeout_sticky", 32'(timeout_err), 32'd1);
        chk("t4_loss_cnt", 32'(lock_loss_cnt), 32'd0);

        // 5: saturation, plus a loss that collides with a stage release
        for (int i = 0; i < 253; i++) loss_relock();
        chk("t5_cnt_253", 32'(lock_loss_cnt), 32'd253);
        mark = cyc;
        push(3,  5'b00_111);
        push(27, 5'b00_110);
        push(31, 5'b00_111);
        push(55, 5'b00_110);
        push(59, 5'b00_100);
        push(63, 5'b01_000);
        pll_locked = 1'b0;
        step(5);
        pll_locked = 1'b1;
        step(23);
        pll_locked = 1'b0;
        step(1);
        chk("t5_mid_release_out", 32'(rst_out), 32'b110);
        chk("t5_cnt_254", 32'(lock_loss_cnt), 32'd254);
        step(2);
        chk("t5_release_loss_cnt", 32'(lock_loss_cnt), 32'd255);
        chk("t5_release_loss_out", 32'(rst_out), 32'b111);
        step(2);
        pll_locked = 1'b1;
        drain("t5_release_drain", 80);
        for (int i = 0; i < 46; i++) loss_relock();
        chk("t5_cnt_saturated", 32'(lock_loss_cnt), 32'd255);
        chk("t5_timeout_sticky", 32'(timeout_err), 32'd1);

        // 6: rst in the middle of RELEASE
        mark = cyc;
        push(3,  5'b00_111);
        push(27, 5'b00_110);
        push(31, 5'b00_100);
        pll_locked = 1'b0;
        step(5);
        pll_locked = 1'b1;
        step(26);
        drain("t6_pre_drain", 5);
        chk("t6_pre_out", 32'(rst_out), 32'b100);
        mon_en = 1'b0;
        rst    = 1'b1;
        step(1);
        chk("t6_pll_rst", 32'(pll_rst), 32'd1);
        chk("t6_rst_out", 32'(rst_out), 32'b111);
        chk("t6_ready", 32'(ready), 32'd0);
        chk("t6_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        chk("t6_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
